// File: rtl/apb_exe_pkg.sv
// Shared types and constants for the execution-unit APB sequencer.
//   seq_state_t : sequencer FSM states
//   xfer_idx_t  : index of the APB transfer within one operation (0..4)
//   ADDR_*      : register map of the execution-unit slave
//   IDX_*       : transfer indices of the fixed five-transfer sequence
package apb_exe_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_EXEC   = 3'd3,
    ST_RESP   = 3'd4
  } seq_state_t;

  typedef logic [2:0] xfer_idx_t;

  localparam int ADDR_OPER   = 0;
  localparam int ADDR_ARGA   = 1;
  localparam int ADDR_ARGB   = 2;
  localparam int ADDR_RESULT = 0;
  localparam int ADDR_STATUS = 1;

  localparam xfer_idx_t IDX_OPER   = 3'd0;
  localparam xfer_idx_t IDX_ARGA   = 3'd1;
  localparam xfer_idx_t IDX_ARGB   = 3'd2;
  localparam xfer_idx_t IDX_RESULT = 3'd3;
  localparam xfer_idx_t IDX_STATUS = 3'd4;

endpackage

// File: rtl/apb_exe_sequencer_if.sv
// APB bus between the sequencer (master) and the execution-unit slave.
//   PADDR/PSEL/PENABLE/PWRITE/PWDATA : request, driven by the master
//   PREADY/PRDATA/PSLVERR            : completion, driven by the slave
interface apb_exe_sequencer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] PADDR;
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic                  PREADY;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PSLVERR;

  modport master (
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    input  PREADY, PRDATA, PSLVERR
  );

  modport slave (
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    output PREADY, PRDATA, PSLVERR
  );
endinterface

// File: rtl/apb_master_xfer.sv
// Single APB transfer engine: SETUP then ACCESS until PREADY or timeout.
//   i_PCLK, i_PRESET : clock, synchronous active-high reset
//   start            : load a new transfer (enters SETUP next cycle)
//   addr/write/wdata : transfer request, sampled with start
//   done             : last ACCESS cycle of the transfer (PREADY or timeout)
//   err              : done with PSLVERR, or timed out
//   rdata            : slave read data, meaningful when done && !err
//   apb              : APB master port (all request signals registered)
module apb_master_xfer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int TIMEOUT    = 15
) (
  input  logic                  i_PCLK,
  input  logic                  i_PRESET,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  write,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  done,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] rdata,
  apb_exe_sequencer_if.master   apb
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic             access;
  logic             timed_out;
  logic [CNT_W-1:0] wait_cnt;

  // wait_cnt holds the number of ACCESS cycles already spent without PREADY,
  // so the TIMEOUT-th ACCESS cycle is the last one allowed.
  assign access    = apb.PSEL && apb.PENABLE;
  assign timed_out = !apb.PREADY && (wait_cnt == CNT_W'(TIMEOUT - 1));
  assign done      = access && (apb.PREADY || timed_out);
  assign err       = access && ((apb.PREADY && apb.PSLVERR) || timed_out);
  assign rdata     = apb.PRDATA;

  always_ff @(posedge i_PCLK) begin
    if (i_PRESET) begin
      apb.PSEL    <= 1'b0;
      apb.PENABLE <= 1'b0;
      apb.PWRITE  <= 1'b0;
      apb.PADDR   <= '0;
      apb.PWDATA  <= '0;
      wait_cnt    <= '0;
    end else if (start) begin
      // start wins over completion so back-to-back transfers need no gap
      apb.PSEL    <= 1'b1;
      apb.PENABLE <= 1'b0;
      apb.PADDR   <= addr;
      apb.PWRITE  <= write;
      apb.PWDATA  <= write ? wdata : '0;
      wait_cnt    <= '0;
    end else if (apb.PSEL && !apb.PENABLE) begin
      apb.PENABLE <= 1'b1;
    end else if (access) begin
      if (done) begin
        // PADDR keeps its last value; write data is cleared on an idle bus
        apb.PSEL    <= 1'b0;
        apb.PENABLE <= 1'b0;
        apb.PWDATA  <= '0;
      end else begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/apb_exe_sequencer.sv
// Runs one operation on the execution-unit APB slave: writes oper/argA/argB,
// idles EXE_LAT cycles, reads result and status, returns them as a response.
//   i_PCLK, i_PRESET            : clock, synchronous active-high reset
//   i_cmd_valid / o_cmd_ready   : command handshake (ready only in IDLE)
//   i_cmd_oper/argA/argB        : command fields
//   o_rsp_valid / i_rsp_ready   : response handshake
//   o_rsp_result/status/err     : read result, status[3:0], abort flag
//   apb                         : APB master port to the execution unit
module apb_exe_sequencer
  import apb_exe_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int EXE_LAT    = 2,
  parameter int TIMEOUT    = 15
) (
  input  logic                  i_PCLK,
  input  logic                  i_PRESET,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic [DATA_WIDTH-1:0] i_cmd_oper,
  input  logic [DATA_WIDTH-1:0] i_cmd_argA,
  input  logic [DATA_WIDTH-1:0] i_cmd_argB,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_rsp_result,
  output logic [3:0]            o_rsp_status,
  output logic                  o_rsp_err,
  apb_exe_sequencer_if.master   apb
);

  localparam int EXEC_W = (EXE_LAT > 1) ? $clog2(EXE_LAT) : 1;

  seq_state_t            state_q;
  xfer_idx_t             idx_q;
  logic [EXEC_W-1:0]     exec_cnt_q;
  logic [DATA_WIDTH-1:0] arg_a_q;
  logic [DATA_WIDTH-1:0] arg_b_q;

  logic                  x_start;
  xfer_idx_t             x_idx;
  logic [ADDR_WIDTH-1:0] x_addr;
  logic                  x_write;
  logic [DATA_WIDTH-1:0] x_wdata;
  logic                  x_done;
  logic                  x_err;
  logic [DATA_WIDTH-1:0] x_rdata;

  // Decide whether a transfer is launched this cycle and which one.
  always_comb begin
    x_start = 1'b0;
    x_idx   = idx_q + 3'd1;
    case (state_q)
      ST_IDLE: begin
        x_start = i_cmd_valid;
        x_idx   = IDX_OPER;
      end
      ST_ACCESS: x_start = x_done && !x_err && (idx_q != IDX_ARGB) && (idx_q != IDX_STATUS);
      ST_EXEC: begin
        x_start = (exec_cnt_q == EXEC_W'(EXE_LAT - 1));
        x_idx   = IDX_RESULT;
      end
      default: ;
    endcase

    x_addr  = '0;
    x_write = 1'b0;
    x_wdata = '0;
    case (x_idx)
      // the oper write is only ever launched from IDLE, in the accept cycle,
      // so it takes the command field straight from the port
      IDX_OPER: begin
        x_addr  = ADDR_WIDTH'(ADDR_OPER);
        x_write = 1'b1;
        x_wdata = i_cmd_oper;
      end
      IDX_ARGA: begin
        x_addr  = ADDR_WIDTH'(ADDR_ARGA);
        x_write = 1'b1;
        x_wdata = arg_a_q;
      end
      IDX_ARGB: begin
        x_addr  = ADDR_WIDTH'(ADDR_ARGB);
        x_write = 1'b1;
        x_wdata = arg_b_q;
      end
      IDX_RESULT: x_addr = ADDR_WIDTH'(ADDR_RESULT);
      IDX_STATUS: x_addr = ADDR_WIDTH'(ADDR_STATUS);
      default: ;
    endcase
  end

  apb_master_xfer #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .TIMEOUT    (TIMEOUT)
  ) u_xfer (
    .i_PCLK   (i_PCLK),
    .i_PRESET (i_PRESET),
    .start    (x_start),
    .addr     (x_addr),
    .write    (x_write),
    .wdata    (x_wdata),
    .done     (x_done),
    .err      (x_err),
    .rdata    (x_rdata),
    .apb      (apb)
  );

  always_ff @(posedge i_PCLK) begin
    if (i_PRESET) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      exec_cnt_q   <= '0;
      o_cmd_ready  <= 1'b1;
      o_rsp_valid  <= 1'b0;
      o_rsp_err    <= 1'b0;
      o_rsp_result <= '0;
      o_rsp_status <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_cmd_valid) begin
            arg_a_q     <= i_cmd_argA;
            arg_b_q     <= i_cmd_argB;
            o_rsp_err   <= 1'b0;
            idx_q       <= IDX_OPER;
            o_cmd_ready <= 1'b0;
            state_q     <= ST_SETUP;
          end
        end
        ST_SETUP: state_q <= ST_ACCESS;
        ST_ACCESS: begin
          if (x_done) begin
            if (x_err) begin
              o_rsp_err    <= 1'b1;
              o_rsp_result <= '0;
              o_rsp_status <= '0;
              o_rsp_valid  <= 1'b1;
              state_q      <= ST_RESP;
            end else begin
              if (idx_q == IDX_RESULT) o_rsp_result <= x_rdata;
              if (idx_q == IDX_STATUS) o_rsp_status <= x_rdata[3:0];
              if (idx_q == IDX_ARGB) begin
                exec_cnt_q <= '0;
                state_q    <= ST_EXEC;
              end else if (idx_q == IDX_STATUS) begin
                o_rsp_valid <= 1'b1;
                state_q     <= ST_RESP;
              end else begin
                idx_q   <= idx_q + 3'd1;
                state_q <= ST_SETUP;
              end
            end
          end
        end
        ST_EXEC: begin
          if (exec_cnt_q == EXEC_W'(EXE_LAT - 1)) begin
            exec_cnt_q <= '0;
            idx_q      <= IDX_RESULT;
            state_q    <= ST_SETUP;
          end else begin
            exec_cnt_q <= exec_cnt_q + EXEC_W'(1);
          end
        end
        ST_RESP: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            o_cmd_ready <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_exe_sequencer.sv
// Bench for apb_exe_sequencer with a behavioural execution-unit slave.
module tb_apb_exe_sequencer;

  localparam int DW      = 8;
  localparam int AW      = 16;
  localparam int EXE_LAT = 2;
  localparam int TIMEOUT = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [DW-1:0] cmd_oper, cmd_a, cmd_b;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_result;
  logic [3:0]    rsp_status;
  logic          rsp_err;

  always #5 clk = ~clk;

  apb_exe_sequencer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) apb ();

  apb_exe_sequencer #(
    .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .EXE_LAT (EXE_LAT), .TIMEOUT (TIMEOUT)
  ) dut (
    .i_PCLK       (clk),
    .i_PRESET     (rst),
    .i_cmd_valid  (cmd_valid),
    .o_cmd_ready  (cmd_ready),
    .i_cmd_oper   (cmd_oper),
    .i_cmd_argA   (cmd_a),
    .i_cmd_argB   (cmd_b),
    .o_rsp_valid  (rsp_valid),
    .i_rsp_ready  (rsp_ready),
    .o_rsp_result (rsp_result),
    .o_rsp_status (rsp_status),
    .o_rsp_err    (rsp_err),
    .apb          (apb)
  );

  // ---------------- execution-unit behaviour ----------------
  function automatic logic [7:0] exe_fn(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op[1:0])
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a ^ b;
    endcase
  endfunction

  function automatic logic [3:0] stat_fn(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    r = exe_fn(op, a, b);
    return {r == 8'h00, r[7], op[1:0]};
  endfunction

  // slave: mode 0 = PREADY on 2nd ACCESS cycle, 1 = zero wait, 2 = never ready
  int          mode = 0;
  logic        err_en = 1'b0, err_wr = 1'b0;
  logic [15:0] err_addr = 16'h0;
  logic        pready_r = 1'b0;
  logic [7:0]  reg_op = 8'h0, reg_a = 8'h0, reg_b = 8'h0;

  typedef struct packed { logic wr; logic [15:0] addr; logic [7:0] data; } xfer_t;
  xfer_t xlog[$];
  int    pen_cnt = 0;

  assign apb.PREADY  = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : pready_r;
  assign apb.PSLVERR = err_en && apb.PSEL && apb.PENABLE && (apb.PWRITE == err_wr) && (apb.PADDR == err_addr);
  assign apb.PRDATA  = !apb.PREADY ? 8'hEE :
                       (apb.PADDR == 16'd0) ? exe_fn(reg_op, reg_a, reg_b) :
                       (apb.PADDR == 16'd1) ? {4'hA, stat_fn(reg_op, reg_a, reg_b)} : 8'h5C;

  always @(posedge clk) begin
    pready_r <= apb.PSEL && apb.PENABLE && !pready_r;
    if (apb.PENABLE) pen_cnt <= pen_cnt + 1;
    if (apb.PSEL && apb.PENABLE && apb.PREADY) begin
      xlog.push_back({apb.PWRITE, apb.PADDR, apb.PWDATA});
      if (apb.PWRITE && !apb.PSLVERR) begin
        if (apb.PADDR == 16'd0) reg_op <= apb.PWDATA;
        if (apb.PADDR == 16'd1) reg_a  <= apb.PWDATA;
        if (apb.PADDR == 16'd2) reg_b  <= apb.PWDATA;
      end
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    int          mode;
    logic        err_en;
    logic        err_wr;
    logic [15:0] err_addr;
    logic [7:0]  oper, a, b;
    logic [7:0]  exp_result;
    logic [3:0]  exp_status;
    logic        exp_err;
    int          exp_lat;
    int          exp_nxfer;
    int          exp_pen;
  } vec_t;

  // APB transfers of one operation, in order: three writes then two reads
  function automatic xfer_t exp_xfer(input int i, input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
    case (i)
      0:       return {1'b1, 16'd0, op};
      1:       return {1'b1, 16'd1, a};
      2:       return {1'b1, 16'd2, b};
      3:       return {1'b0, 16'd0, 8'h00};
      default: return {1'b0, 16'd1, 8'h00};
    endcase
  endfunction

  // n ACCESS cycles per transfer: 5 transfers of (1+n) cycles, the EXEC wait,
  // and the response appears one cycle later
  function automatic vec_t model_vec(input int md, input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
    vec_t v;
    int   n;
    n = (md == 1) ? 1 : 2;
    v.mode = md; v.err_en = 1'b0; v.err_wr = 1'b0; v.err_addr = 16'h0;
    v.oper = op; v.a = a; v.b = b;
    v.exp_result = exe_fn(op, a, b);
    v.exp_status = stat_fn(op, a, b);
    v.exp_err    = 1'b0;
    v.exp_lat    = 5 * (1 + n) + EXE_LAT + 1;
    v.exp_nxfer  = 5;
    v.exp_pen    = 5 * n;
    return v;
  endfunction

  // ---------------- checking helpers ----------------
  int n_checks = 0;
  int n_errors = 0;
  int pen0, log0, busy_ready;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " ctrl"}, {cmd_ready, rsp_valid, rsp_err}, 3'b100);
    check({tag, " rsp data"}, {rsp_result, rsp_status}, 12'h000);
    check({tag, " apb ctrl"}, {apb.PSEL, apb.PENABLE, apb.PWRITE}, 3'b000);
    check({tag, " paddr"}, apb.PADDR, 16'h0);
    check({tag, " pwdata"}, apb.PWDATA, 8'h0);
  endtask

  // call #1 after a clock edge with the DUT idle; returns in cycle 1 after accept
  task automatic issue(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
    cmd_oper = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    check("cmd_ready idle", cmd_ready, 1);
    pen0 = pen_cnt; log0 = xlog.size(); busy_ready = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 100) begin
      if (cmd_ready) busy_ready++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic check_rsp(input string tag, input vec_t v, input int lat);
    int n;
    check({tag, " latency"}, lat, v.exp_lat);
    check({tag, " result"}, rsp_result, v.exp_result);
    check({tag, " status"}, rsp_status, v.exp_status);
    check({tag, " err"}, rsp_err, v.exp_err);
    check({tag, " bus idle in resp"}, {apb.PSEL, apb.PENABLE, cmd_ready}, 3'b000);
    check({tag, " cmd_ready while busy"}, busy_ready, 0);
    n = xlog.size() - log0;
    check({tag, " transfer count"}, n, v.exp_nxfer);
    for (int i = 0; i < n && i < v.exp_nxfer; i++)
      check($sformatf("%s transfer%0d", tag, i), xlog[log0 + i], exp_xfer(i, v.oper, v.a, v.b));
    check({tag, " penable cycles"}, pen_cnt - pen0, v.exp_pen);
  endtask

  task automatic consume(input string tag, input vec_t v, input int hold);
    rsp_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, " held rsp"}, {rsp_valid, cmd_ready, rsp_result, rsp_status, rsp_err},
            {1'b1, 1'b0, v.exp_result, v.exp_status, v.exp_err});
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({tag, " released"}, {rsp_valid, cmd_ready}, 2'b01);
  endtask

  task automatic run_vec(input string tag, input vec_t v, input int hold);
    int lat;
    mode = v.mode; err_en = v.err_en; err_wr = v.err_wr; err_addr = v.err_addr;
    issue(v.oper, v.a, v.b);
    wait_rsp(lat);
    check_rsp(tag, v, lat);
    consume(tag, v, hold);
    mode = 0; err_en = 1'b0;
  endtask

  vec_t vt[8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat, seen_rsp, seen_sel, hold, gap, md;
    vec_t v;

    //        mode en   wr   addr   oper   A      B      result status err  lat nx pen
    vt[0] = '{0, 1'b0, 1'b0, 16'h0, 8'h03, 8'h12, 8'h05, 8'h17, 4'h3, 1'b0, 18, 5, 10};
    vt[1] = '{0, 1'b0, 1'b0, 16'h0, 8'h00, 8'hF0, 8'h10, 8'h00, 4'h8, 1'b0, 18, 5, 10};
    vt[2] = '{0, 1'b0, 1'b0, 16'h0, 8'h01, 8'h05, 8'h07, 8'hFE, 4'h5, 1'b0, 18, 5, 10};
    vt[3] = '{0, 1'b0, 1'b0, 16'h0, 8'h02, 8'hC3, 8'h81, 8'h81, 4'h6, 1'b0, 18, 5, 10};
    vt[4] = '{1, 1'b0, 1'b0, 16'h0, 8'h03, 8'h55, 8'hAA, 8'hFF, 4'h7, 1'b0, 13, 5, 5};
    vt[5] = '{0, 1'b1, 1'b1, 16'h1, 8'h00, 8'h22, 8'h33, 8'h00, 4'h0, 1'b1, 7,  2, 4};
    vt[6] = '{0, 1'b1, 1'b0, 16'h1, 8'h01, 8'h40, 8'h01, 8'h00, 4'h0, 1'b1, 18, 5, 10};
    vt[7] = '{2, 1'b0, 1'b0, 16'h0, 8'h02, 8'h0F, 8'hF0, 8'h00, 4'h0, 1'b1, 17, 0, 15};

    rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_oper = '0; cmd_a = '0; cmd_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++)
      run_vec($sformatf("vec%0d", i), vt[i], 0);

    // response backpressure with a second command waiting
    v = model_vec(0, 8'h03, 8'h12, 8'h05);
    issue(v.oper, v.a, v.b);
    wait_rsp(lat);
    check_rsp("bp first", v, lat);
    cmd_oper = 8'h00; cmd_a = 8'h01; cmd_b = 8'h02; cmd_valid = 1'b1;
    consume("bp", v, 10);
    pen0 = pen_cnt; log0 = xlog.size(); busy_ready = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("bp second accepted", cmd_ready, 0);
    v = model_vec(0, 8'h00, 8'h01, 8'h02);
    wait_rsp(lat);
    check_rsp("bp second", v, lat);
    consume("bp second", v, 0);

    // reset during the EXEC wait
    issue(8'h01, 8'h30, 8'h10);
    repeat (9) begin @(posedge clk); #1; end
    check("exec bus idle", {apb.PSEL, apb.PADDR}, {1'b0, 16'd2});
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_vals("mid reset");
    seen_rsp = 0; seen_sel = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (rsp_valid) seen_rsp++;
      if (apb.PSEL) seen_sel++;
    end
    check("mid reset no response", seen_rsp, 0);
    check("mid reset no transfers", seen_sel, 0);

    // randomized commands against the model
    for (int i = 0; i < 20; i++) begin
      md   = int'($urandom_range(0, 1));
      v    = model_vec(md, 8'($urandom), 8'($urandom), 8'($urandom));
      hold = int'($urandom_range(0, 3));
      gap  = int'($urandom_range(0, 2));
      run_vec($sformatf("rand%0d", i), v, hold);
      repeat (gap) begin @(posedge clk); #1; end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
